// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states,
// reset vector, fetch increment and word-alignment mask.
package if_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } if_state_e;

    localparam logic [31:0] IF_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned IF_PC_INCR      = 4;
    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;
    localparam logic [31:0] IF_COUNT_MAX    = 32'hFFFF_FFFF;

    // True when a byte address is not on a 32-bit word boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return |(addr[1:0] & WORD_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_adder.sv
// Combinational PC + INCR, modulo 2^32 with no carry out. Also used by
// the branch-target adder in ID.
module pc_adder #(
    parameter int unsigned INCR = 4
) (
    input  logic [31:0] i_pc,
    output logic [31:0] o_sum
);

    assign o_sum = i_pc + 32'(INCR);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, applies hazard stalls and
// branch/jump redirects, and squashes the IF/ID register on wrong-path
// fetches. A misaligned redirect target parks the unit in FAULT until reset.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = IF_RESET_VECTOR,
    parameter int unsigned PC_INCR      = IF_PC_INCR
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PCWrite,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic        Jump,
    input  logic [31:0] Jump_target,
    output logic [31:0] PC_out,
    output logic [31:0] PCAdder_out,
    output logic        IFID_flush,
    output logic        Fetch_valid,
    output logic        Misalign_err,
    output logic [31:0] Instr_count
);

    if_state_e   r_state;
    logic [31:0] r_pc;
    logic        r_misalign_err;
    logic [31:0] r_instr_count;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_target_bad;
    logic [31:0] w_pc_plus;

    // Branch is the older instruction, so it wins when both redirect.
    assign w_redirect   = Branch_taken | Jump;
    assign w_target     = Branch_taken ? Branch_target : Jump_target;
    assign w_target_bad = is_misaligned(w_target);

    pc_adder #(
        .INCR (PC_INCR)
    ) u_pc_adder (
        .i_pc  (r_pc),
        .o_sum (w_pc_plus)
    );

    // Fetch FSM: PC, fault flag and retired-into-IF/ID counter.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state        <= ST_BOOT;
            r_pc           <= RESET_VECTOR;
            r_misalign_err <= 1'b0;
            r_instr_count  <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    // One settling cycle; inputs are ignored.
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_redirect) begin
                        if (w_target_bad) begin
                            // PC stays put so the faulting fetch address is visible.
                            r_state        <= ST_FAULT;
                            r_misalign_err <= 1'b1;
                        end else begin
                            r_pc <= w_target;
                        end
                    end else if (PCWrite) begin
                        r_pc <= w_pc_plus;
                        if (r_instr_count != IF_COUNT_MAX) begin
                            r_instr_count <= r_instr_count + 32'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    // Frozen until reset.
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign PC_out       = r_pc;
    assign PCAdder_out  = w_pc_plus;
    // Outside RUN every fetch is squashed; in RUN only redirects squash.
    assign IFID_flush   = (r_state != ST_RUN) | w_redirect;
    assign Fetch_valid  = (r_state == ST_RUN);
    assign Misalign_err = r_misalign_err;
    assign Instr_count  = r_instr_count;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a random
// run, all compared against a behavioural model of the fetch rules.
module tb_if_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        PCWrite;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic        Jump;
    logic [31:0] Jump_target;
    logic [31:0] PC_out;
    logic [31:0] PCAdder_out;
    logic        IFID_flush;
    logic        Fetch_valid;
    logic        Misalign_err;
    logic [31:0] Instr_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int          m_st;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_err;
    bit          exp_flush;
    logic        obs_flush;

    always #5 Clk = ~Clk;

    if_fetch_unit #(
        .RESET_VECTOR (RV),
        .PC_INCR      (4)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .PCWrite       (PCWrite),
        .Branch_taken  (Branch_taken),
        .Branch_target (Branch_target),
        .Jump          (Jump),
        .Jump_target   (Jump_target),
        .PC_out        (PC_out),
        .PCAdder_out   (PCAdder_out),
        .IFID_flush    (IFID_flush),
        .Fetch_valid   (Fetch_valid),
        .Misalign_err  (Misalign_err),
        .Instr_count   (Instr_count)
    );

    task automatic model_reset();
        m_st  = M_BOOT;
        m_pc  = RV;
        m_cnt = 32'd0;
        m_err = 1'b0;
    endtask

    // Apply one cycle of inputs, sample the combinational flush, advance the model.
    task automatic cycle(input bit pcw, input bit br, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt);
        logic [31:0] tgt;
        @(negedge Clk);
        PCWrite = pcw; Branch_taken = br; Branch_target = bt;
        Jump = j; Jump_target = jt;
        #1;
        obs_flush = IFID_flush;
        exp_flush = (m_st != M_RUN) || br || j;
        if (m_st == M_BOOT) begin
            m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            if (br || j) begin
                tgt = br ? bt : jt;
                if (tgt % 4 == 0) m_pc = tgt;
                else begin m_st = M_FAULT; m_err = 1'b1; end
            end else if (pcw) begin
                m_pc = m_pc + 32'd4;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    // Hold reset across one rising edge, then release just after it.
    task automatic hold_reset_then_release();
        @(posedge Clk);
        #1;
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b0; PCWrite = 0; Branch_taken = 0; Jump = 0;
        Branch_target = 0; Jump_target = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (PC_out !== RV) begin errors++; $display("FAIL reset_pc got %h exp %h", PC_out, RV); end
        checks++; if (PCAdder_out !== RV + 32'd4) begin errors++; $display("FAIL reset_adder got %h exp %h", PCAdder_out, RV + 32'd4); end
        checks++; if (IFID_flush !== 1'b1) begin errors++; $display("FAIL reset_flush got %b exp 1", IFID_flush); end
        checks++; if (Fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", Fetch_valid); end
        checks++; if (Misalign_err !== 1'b0 || Instr_count !== 32'd0) begin errors++; $display("FAIL reset_err_cnt got %b/%h exp 0/0", Misalign_err, Instr_count); end
        hold_reset_then_release();
        // BOOT cycle: redirect and advance must be ignored.
        cycle(1, 1, 32'h40, 0, 0);
        checks++; if (obs_flush !== 1'b1) begin errors++; $display("FAIL boot_flush got %b exp 1", obs_flush); end
        checks++; if (PC_out !== RV) begin errors++; $display("FAIL boot_pc_hold got %h exp %h", PC_out, RV); end
        checks++; if (Fetch_valid !== 1'b1) begin errors++; $display("FAIL run_valid got %b exp 1", Fetch_valid); end
    endtask

    task automatic test_advance();
        for (int k = 1; k <= 4; k++) begin
            cycle(1, 0, 0, 0, 0);
            checks++; if (PC_out !== 32'(4 * k) || PC_out !== m_pc) begin errors++; $display("FAIL advance_pc step %0d got %h exp %h", k, PC_out, 32'(4 * k)); end
            checks++; if (obs_flush !== 1'b0) begin errors++; $display("FAIL advance_flush step %0d got %b exp 0", k, obs_flush); end
        end
        checks++; if (Instr_count !== 32'd4) begin errors++; $display("FAIL advance_count got %0d exp 4", Instr_count); end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 0);
            checks++; if (PC_out !== 32'h10 || PCAdder_out !== 32'h14) begin errors++; $display("FAIL stall_pc got %h/%h exp 10/14", PC_out, PCAdder_out); end
            checks++; if (obs_flush !== 1'b0 || Instr_count !== 32'd4) begin errors++; $display("FAIL stall_flush_cnt got %b/%0d exp 0/4", obs_flush, Instr_count); end
        end
    endtask

    task automatic test_branch_tie();
        repeat (4) cycle(1, 0, 0, 0, 0);
        checks++; if (PC_out !== 32'h20) begin errors++; $display("FAIL tie_setup_pc got %h exp 20", PC_out); end
        cycle(0, 1, 32'h100, 1, 32'h200);
        checks++; if (obs_flush !== 1'b1) begin errors++; $display("FAIL tie_flush got %b exp 1", obs_flush); end
        checks++; if (PC_out !== 32'h100) begin errors++; $display("FAIL tie_pc got %h exp 100", PC_out); end
        checks++; if (Instr_count !== 32'd8) begin errors++; $display("FAIL tie_cnt got %0d exp 8", Instr_count); end
        cycle(0, 0, 0, 0, 0);
        checks++; if (obs_flush !== 1'b0) begin errors++; $display("FAIL tie_after_flush got %b exp 0", obs_flush); end
    endtask

    task automatic test_misalign();
        cycle(0, 0, 0, 1, 32'h102);
        checks++; if (obs_flush !== 1'b1) begin errors++; $display("FAIL mis_flush got %b exp 1", obs_flush); end
        checks++; if (PC_out !== 32'h100) begin errors++; $display("FAIL mis_pc_hold got %h exp 100", PC_out); end
        checks++; if (Misalign_err !== 1'b1 || Fetch_valid !== 1'b0) begin errors++; $display("FAIL mis_err_valid got %b/%b exp 1/0", Misalign_err, Fetch_valid); end
        for (int k = 0; k < 5; k++) begin
            cycle(1, 1, 32'h300, 0, 0);
            checks++; if (PC_out !== 32'h100 || obs_flush !== 1'b1) begin errors++; $display("FAIL fault_frozen step %0d got %h/%b exp 100/1", k, PC_out, obs_flush); end
        end
        // Asynchronous reset in the middle of a cycle.
        @(negedge Clk);
        #2;
        Rst = 1'b0;
        model_reset();
        #1;
        checks++; if (PC_out !== RV || Misalign_err !== 1'b0) begin errors++; $display("FAIL async_reset got %h/%b exp %h/0", PC_out, Misalign_err, RV); end
        checks++; if (Instr_count !== 32'd0 || Fetch_valid !== 1'b0) begin errors++; $display("FAIL async_reset_cnt got %0d/%b exp 0/0", Instr_count, Fetch_valid); end
        hold_reset_then_release();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        cycle(0, 1, 32'hFFFF_FFFC, 0, 0);
        checks++; if (PC_out !== 32'hFFFF_FFFC || PCAdder_out !== 32'h0) begin errors++; $display("FAIL wrap_branch got %h/%h exp fffffffc/0", PC_out, PCAdder_out); end
        cycle(1, 0, 0, 0, 0);
        checks++; if (PC_out !== 32'h0 || PCAdder_out !== 32'h4) begin errors++; $display("FAIL wrap_pc got %h/%h exp 0/4", PC_out, PCAdder_out); end
        checks++; if (Misalign_err !== 1'b0 || Fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap_nofault got %b/%b exp 0/1", Misalign_err, Fetch_valid); end
    endtask

    task automatic test_saturate();
        @(negedge Clk);
        PCWrite = 0; Branch_taken = 0; Jump = 0;
        force dut.r_instr_count = 32'hFFFF_FFFD;
        @(posedge Clk);
        #1;
        release dut.r_instr_count;
        m_cnt = 32'hFFFF_FFFD;
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, 0, 0, 0);
            checks++; if (Instr_count !== m_cnt) begin errors++; $display("FAIL sat_step %0d got %h exp %h", k, Instr_count, m_cnt); end
        end
        checks++; if (Instr_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_final got %h exp ffffffff", Instr_count); end
    endtask

    task automatic test_random();
        logic [31:0] bt, jt;
        bit pcw, br, j;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0 || (m_st == M_FAULT && $urandom_range(0, 4) == 0)) begin
                @(negedge Clk);
                #1;
                Rst = 1'b0;
                model_reset();
                #1;
                checks++; if (PC_out !== RV || Misalign_err !== 1'b0 || Instr_count !== 32'd0) begin errors++; $display("FAIL rand_reset %0d got %h/%b/%h", n, PC_out, Misalign_err, Instr_count); end
                hold_reset_then_release();
            end
            pcw = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 5) == 0);
            j   = ($urandom_range(0, 5) == 0);
            bt  = {$urandom(), 2'b00} >> 2 << 2;
            jt  = $urandom() & 32'hFFFF_FFFC;
            bt  = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) bt = bt | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) jt = jt | 32'($urandom_range(1, 3));
            cycle(pcw, br, bt, j, jt);
            checks++; if (obs_flush !== exp_flush) begin errors++; $display("FAIL rand_flush %0d got %b exp %b", n, obs_flush, exp_flush); end
            checks++; if (PC_out !== m_pc) begin errors++; $display("FAIL rand_pc %0d got %h exp %h", n, PC_out, m_pc); end
            checks++; if (PCAdder_out !== m_pc + 32'd4) begin errors++; $display("FAIL rand_adder %0d got %h exp %h", n, PCAdder_out, m_pc + 32'd4); end
            checks++; if (Fetch_valid !== (m_st == M_RUN)) begin errors++; $display("FAIL rand_valid %0d got %b exp %b", n, Fetch_valid, m_st == M_RUN); end
            checks++; if (Misalign_err !== m_err) begin errors++; $display("FAIL rand_err %0d got %b exp %b", n, Misalign_err, m_err); end
            checks++; if (Instr_count !== m_cnt) begin errors++; $display("FAIL rand_cnt %0d got %h exp %h", n, Instr_count, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_stall();
        test_branch_tie();
        test_misalign();
        test_wrap();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter, computes PC+4, and applies hazard-unit stalls and branch/jump redirects. It also generates the IF/ID flush for wrong-path squashing. PC_out drives the combinational instruction memory. PCAdder_out and IFID_flush feed the IF/ID register directly.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
PC_INCR, 4, sequential fetch increment in bytes.

Ports:
Clk  in  1  sole clock; all state updates on posedge.
Rst  in  1  asynchronous, active-low reset (asserted when 0).
PCWrite  in  1  hazard unit; 1 = advance PC, 0 = hold PC (stall).
Branch_taken  in  1  resolved taken branch this cycle.
Branch_target  in  32  byte address for a taken branch.
Jump  in  1  jump redirect this cycle.
Jump_target  in  32  byte address for a jump.
PC_out  out  32  current fetch address to instruction memory.
PCAdder_out  out  32  PC_out + PC_INCR, combinational from PC register.
IFID_flush  out  1  squash the instruction currently in IF (combinational).
Fetch_valid  out  1  1 when the instruction at PC_out is a real fetch.
Misalign_err  out  1  sticky fault flag.
Instr_count  out  32  count of instructions advanced into IF/ID.

Behaviour:
- FSM states: BOOT, RUN, FAULT. Encoding is defined in the package.
- Rst=0 (asynchronous): state=BOOT, PC=RESET_VECTOR, Instr_count=0, Misalign_err=0. While reset is held, outputs are PC_out=RESET_VECTOR, PCAdder_out=RESET_VECTOR+4, IFID_flush=1, Fetch_valid=0.
- BOOT: lasts exactly one cycle after Rst deasserts. IFID_flush=1, Fetch_valid=0, PC holds, then the FSM moves to RUN. Redirects and PCWrite are ignored in BOOT.
- RUN, decision priority per cycle, highest first:
  - Branch_taken=1 (branch is older than jump; branch wins on a tie): target=Branch_target.
  - else Jump=1: target=Jump_target.
  - else PCWrite=1: PC <= PC+4 at next posedge.
  - else: PC holds.
- Redirects override stall: a redirect with PCWrite=0 still loads the target.
- Redirect with target[1:0]==0: PC <= target at next posedge. IFID_flush=1 in the same cycle, combinationally, so the IF/ID register captures a bubble. Latency is 1 cycle from redirect to PC_out=target.
- Redirect with target[1:0]!=0: PC is not loaded. IFID_flush=1. Next state is FAULT and Misalign_err <= 1.
- IFID_flush=0 in RUN whenever there is no redirect.
- Fetch_valid=1 in RUN, 0 in BOOT and FAULT.
- FAULT: PC frozen, IFID_flush=1, Fetch_valid=0, Misalign_err=1. All inputs are ignored. Only Rst exits FAULT.
- Instr_count: increments by 1 on a posedge in RUN with PCWrite=1 and no redirect. Saturates at 32'hFFFF_FFFF.
- Wrap-around: PC=32'hFFFF_FFFC with advance gives PC=0. PCAdder_out is the modulo-2^32 sum, with no carry flag.
- Reset mid-operation (any state, any cycle): immediate return to BOOT values. No partial update survives.
- PC[1:0] is always 00.

Decomposition:
- Shared package if_pkg: FSM state enum, default RESET_VECTOR, PC_INCR, WORD_ALIGN_MASK=2'b11.
- One sub-module, pc_adder: 32-bit combinational PC+PC_INCR. It is reused by the branch-target adder in ID.

Test Plan:
- Reset release -> cycle 0: PC_out=0, IFID_flush=1, Fetch_valid=0. Cycle 1: Fetch_valid=1. Then PCWrite=1 for 4 cycles gives PC_out 0,4,8,C,10 and Instr_count=4.
- From PC=0x10, PCWrite=0 for 3 cycles -> PC_out stays 0x10, PCAdder_out=0x14, Instr_count unchanged, IFID_flush=0.
- At PC=0x20, Branch_taken=1, Branch_target=0x100, Jump=1, Jump_target=0x200, PCWrite=0 -> IFID_flush=1 that cycle; next cycle PC_out=0x100, IFID_flush=0.
- Jump_target=0x102 -> IFID_flush=1 and PC holds. Next cycle Misalign_err=1, Fetch_valid=0. Stimulus over the next 5 cycles (PCWrite=1, Branch_taken=1) leaves PC unchanged. Pulse Rst=0 mid-cycle -> PC_out=RESET_VECTOR immediately, Misalign_err=0.
- Branch to 0xFFFF_FFFC, then PCWrite=1 -> PC_out=0, PCAdder_out=4, with no fault.
- Instr_count preloaded near saturation (via force) -> holds at 0xFFFF_FFFF on further advances.
